// File: rtl/uart_ctrl.sv
// Bus-facing UART controller: DATA/STATUS register map, RX byte queue with sticky overrun, TX handshake FSM.
// Define UART_CTRL_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise a single holding register is used.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ce,
  input  logic       req_we,
  input  logic       req_addr,
  input  logic [7:0] req_wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       rx_read_ce,
  input  logic       rx_fin,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

`ifdef UART_CTRL_RX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_e;

  tx_state_e       state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            ack_q, ack_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rx_fin_q, armed_q;
  logic            overrun_q, overrun_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [2**AW];

  logic tx_ready, accept, rd_data, rd_stat, wr_data;
  logic empty, full, rise, push, pop, ovr_evt;
  logic [7:0] status;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tx_ready = (state_q == S_IDLE) && !tx_busy;
  // Never accept in an ack cycle: the master still holds req_ce there.
  assign accept   = req_ce && !ack_q && !(req_we && !req_addr && !tx_ready);
  assign rd_data  = accept && !req_we && !req_addr;
  assign rd_stat  = accept && !req_we &&  req_addr;
  assign wr_data  = accept &&  req_we && !req_addr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // armed_q masks an edge that coincides with reset release.
  assign rise    = armed_q && rx_fin && !rx_fin_q;
  assign pop     = rd_data && !empty;
  assign push    = rise && (!full || pop);
  assign ovr_evt = rise && full && !pop;
  assign status  = {4'b0000, full, overrun_q, !empty, tx_ready};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d = ovr_evt | (overrun_q & ~rd_stat);
    ack_d     = accept;
    rdata_d   = 8'h00;
    if (rd_data && !empty) rdata_d = mem_q[rd_ptr_q];
    else if (rd_stat)      rdata_d = status;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: if (wr_data) begin
        state_d   = S_START;
        tx_data_d = req_wdata;
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= 8'h00;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      rx_fin_q  <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rx_fin_q  <= rx_fin;
      armed_q   <= 1'b1;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign rx_read_ce = !full;
  assign tx_start   = (state_q == S_START);
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: RX queue model plus read-data scoreboard, mock transmitter on tx_start.
module tb_uart_ctrl;
`ifdef UART_CTRL_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, req_ce, req_we, req_addr, rx_fin;
  logic [7:0] req_wdata, rx_data;
  logic       ack, rx_read_ce, tx_start;
  logic [7:0] rdata, tx_data;
  logic       tx_busy = 1'b0;

  int checks = 0, failures = 0;
  int starts = 0, busy_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         model_ovr = 1'b0;

  uart_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .rx_read_ce(rx_read_ce),
    .rx_fin(rx_fin), .rx_data(rx_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Mock transmitter: busy for 10 cycles after each tx_start, dropped by reset.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else if (tx_start) begin
      starts++;
      last_tx  = tx_data;
      tx_busy  = 1'b1;
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] stat_exp();
    return {4'b0000, model_q.size() == DEPTH, model_ovr, model_q.size() != 0, 1'b1};
  endfunction

  function automatic void model_frame(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic frame(input logic [7:0] b);
    rx_data = b;
    rx_fin  = 1'b1;
    step();
    rx_fin  = 1'b0;
    step();
    model_frame(b);
  endtask

  task automatic bus(input string tag, input logic we, input logic addr, input logic [7:0] wd);
    logic [7:0] e;
    if (!we) begin
      if (!addr) e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
      else begin
        e = stat_exp();
        model_ovr = 1'b0;
      end
      exp_q.push_back(e);
    end
    req_ce = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ack) break;
    end
    chk({tag, "_ack"}, ack, 1);
    if (!we) chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    step();
    chk({tag, "_noreack"}, ack, 0);
    req_ce = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    logic [7:0] e;
    rst = 1'b0; req_ce = 1'b0; req_we = 1'b0; req_addr = 1'b0; req_wdata = 8'h00;
    rx_fin = 1'b0; rx_data = 8'h00;
    repeat (3) step();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_txstart", tx_start, 0);
    chk("rst_txdata", tx_data, 8'h00);
    chk("rst_rxce", rx_read_ce, 1);
    rst = 1'b1;
    step();

    // two frames, two data reads, status shows drained queue
    frame(8'h41);
    frame(8'h42);
    bus("rd1", 1'b0, 1'b0, 8'h00);
    bus("rd2", 1'b0, 1'b0, 8'h00);
    bus("st_drained", 1'b0, 1'b1, 8'h00);

    // overflow: five frames without reads
    for (int i = 0; i < 5; i++) begin
      frame(8'h10 + 8'(i));
      chk($sformatf("rxce_after_%0d", i + 1), rx_read_ce, (model_q.size() < DEPTH) ? 1 : 0);
    end
    bus("st_ovr", 1'b0, 1'b1, 8'h00);
    bus("st_ovr_clr", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i <= DEPTH; i++) bus($sformatf("drain%0d", i), 1'b0, 1'b0, 8'h00);

    // full queue, pop and frame land on the same edge
    for (int i = 0; i < DEPTH; i++) frame(8'h20 + 8'(i));
    chk("full_rxce", rx_read_ce, 0);
    e = model_q.pop_front();
    model_q.push_back(8'h7E);
    req_ce = 1'b1; req_we = 1'b0; req_addr = 1'b0; rx_data = 8'h7E; rx_fin = 1'b1;
    step();
    chk("popush_ack", ack, 1);
    chk("popush_rdata", rdata, e);
    rx_fin = 1'b0;
    step();
    chk("popush_noreack", ack, 0);
    req_ce = 1'b0;
    bus("st_popush", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) bus($sformatf("pp_drain%0d", i), 1'b0, 1'b0, 8'h00);
    bus("st_empty", 1'b0, 1'b1, 8'h00);

    // status writes are acked and ignored
    bus("st_wr", 1'b1, 1'b1, 8'hFF);
    bus("st_after_wr", 1'b0, 1'b1, 8'h00);

    // transmit, then a second write that must stall while busy
    s0 = starts;
    bus("tx1", 1'b1, 1'b0, 8'h55);
    req_ce = 1'b1; req_we = 1'b1; req_addr = 1'b0; req_wdata = 8'hA3;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ack) break;
      n++;
    end
    chk("tx2_ack", ack, 1);
    chk("tx2_stalled", (n >= 8) ? 1 : 0, 1);
    chk("tx1_starts", starts - s0, 1);
    chk("tx1_data", last_tx, 8'h55);
    step();
    chk("tx2_noreack", ack, 0);
    req_ce = 1'b0;
    repeat (5) step();
    chk("tx2_busy", tx_busy, 1);
    chk("tx2_held", tx_data, 8'hA3);
    repeat (12) step();
    chk("tx2_starts", starts - s0, 2);
    chk("tx2_data", last_tx, 8'hA3);

    // held rx_fin level counts once
    rx_data = 8'h3C;
    rx_fin  = 1'b1;
    repeat (20) step();
    rx_fin = 1'b0;
    step();
    model_frame(8'h3C);
    bus("st_level", 1'b0, 1'b1, 8'h00);
    bus("lvl_rd", 1'b0, 1'b0, 8'h00);
    bus("lvl_rd_empty", 1'b0, 1'b0, 8'h00);

    // reset during WAIT_DONE with queued bytes; frame edge at release is ignored
    frame(8'h61);
    frame(8'h62);
    bus("tx3", 1'b1, 1'b0, 8'h5A);
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_txstart", tx_start, 0);
    chk("mid_rst_txdata", tx_data, 8'h00);
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_rxce", rx_read_ce, 1);
    step();
    model_q.delete();
    model_ovr = 1'b0;
    rx_data = 8'h99;
    rx_fin  = 1'b1;
    rst     = 1'b1;
    step();
    rx_fin = 1'b0;
    step();
    bus("st_post_rst", 1'b0, 1'b1, 8'h00);
    bus("rd_post_rst", 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
